// File: rtl/eth_tx_sched.sv
// Transmit scheduler: arbitrates ARP/ICMP/UDP frame engines onto one GMII TX port
// with fixed priority and an enforced inter-frame gap. Optional watchdog: ETH_TX_TIMEOUT_EN.
module eth_tx_sched #(
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arp_req,
    input  logic       icmp_req,
    input  logic       udp_req,
    output logic       arp_start,
    output logic       icmp_start,
    output logic       udp_start,
    input  logic       arp_done,
    input  logic       icmp_done,
    input  logic       udp_done,
    input  logic       arp_gmii_tx_en,
    input  logic [7:0] arp_gmii_txd,
    input  logic       icmp_gmii_tx_en,
    input  logic [7:0] icmp_gmii_txd,
    input  logic       udp_gmii_tx_en,
    input  logic [7:0] udp_gmii_txd,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic [1:0] owner,
    output logic       busy,
    output logic       abort
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_IFG    = 2'd2;

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
    localparam logic [IFG_W-1:0] IFG_LOAD = (IFG_CYCLES > 0) ? IFG_W'(IFG_CYCLES - 1) : '0;

    logic [2:0]       req_vec, done_vec, en_vec;
    logic [7:0]       txd_vec [3];
    logic [2:0]       pend_reg, start_reg, start_next;
    logic [1:0]       state_reg, state_next;
    logic [1:0]       owner_reg, owner_next;
    logic [IFG_W-1:0] ifg_cnt_reg, ifg_cnt_next;
    logic             gmii_en_reg, gmii_en_next;
    logic [7:0]       gmii_txd_reg, gmii_txd_next;
    logic             owner_done, owner_en, timeout_hit, end_frame;
    logic [7:0]       owner_txd;

    assign req_vec    = {udp_req, icmp_req, arp_req};
    assign done_vec   = {udp_done, icmp_done, arp_done};
    assign en_vec     = {udp_gmii_tx_en, icmp_gmii_tx_en, arp_gmii_tx_en};
    assign txd_vec[0] = arp_gmii_txd;
    assign txd_vec[1] = icmp_gmii_txd;
    assign txd_vec[2] = udp_gmii_txd;

    // A req wins over the grant-time clear so a request landing on its own grant edge is kept.
    for (genvar gi = 0; gi < 3; gi++) begin : g_pend
        logic pend_q;
        always_ff @(posedge clk) begin
            if (rst)
                pend_q <= 1'b0;
            else if (req_vec[gi])
                pend_q <= 1'b1;
            else if (start_next[gi])
                pend_q <= 1'b0;
        end
        assign pend_reg[gi] = pend_q;
    end

    always_comb begin
        owner_done = 1'b0;
        owner_en   = 1'b0;
        owner_txd  = 8'h00;
        if (owner_reg != 2'd0) begin
            owner_done = done_vec[owner_reg - 2'd1];
            owner_en   = en_vec[owner_reg - 2'd1];
            owner_txd  = txd_vec[owner_reg - 2'd1];
        end
    end

`ifdef ETH_TX_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst)
            wd_cnt_reg <= '0;
        else if (state_reg == ST_ACTIVE && !end_frame)
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
        else
            wd_cnt_reg <= '0;
    end

    assign timeout_hit = (state_reg == ST_ACTIVE) && !owner_done &&
                         (wd_cnt_reg == WD_W'(TIMEOUT_CYCLES - 1));
    assign abort = timeout_hit;
`else
    assign timeout_hit = 1'b0;
    assign abort       = 1'b0;
`endif

    assign end_frame = owner_done | timeout_hit;

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        ifg_cnt_next = ifg_cnt_reg;
        start_next   = 3'b000;
        case (state_reg)
            ST_IDLE: begin
                ifg_cnt_next = '0;
                if (pend_reg[0]) begin
                    state_next = ST_ACTIVE;
                    owner_next = 2'd1;
                    start_next = 3'b001;
                end else if (pend_reg[1]) begin
                    state_next = ST_ACTIVE;
                    owner_next = 2'd2;
                    start_next = 3'b010;
                end else if (pend_reg[2]) begin
                    state_next = ST_ACTIVE;
                    owner_next = 2'd3;
                    start_next = 3'b100;
                end
            end
            ST_ACTIVE: begin
                if (end_frame) begin
                    if (IFG_CYCLES == 0) begin
                        state_next = ST_IDLE;
                        owner_next = 2'd0;
                    end else begin
                        state_next   = ST_IFG;
                        ifg_cnt_next = IFG_LOAD;
                    end
                end
            end
            ST_IFG: begin
                if (ifg_cnt_reg == '0) begin
                    state_next = ST_IDLE;
                    owner_next = 2'd0;
                end else begin
                    ifg_cnt_next = ifg_cnt_reg - 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                owner_next = 2'd0;
            end
        endcase
    end

    // Output stage samples the owner while ACTIVE (done cycle included); an abort blanks it.
    always_comb begin
        gmii_en_next  = 1'b0;
        gmii_txd_next = 8'h00;
        if (state_reg == ST_ACTIVE && !timeout_hit) begin
            gmii_en_next  = owner_en;
            gmii_txd_next = owner_txd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= 2'd0;
            ifg_cnt_reg  <= '0;
            start_reg    <= 3'b000;
            gmii_en_reg  <= 1'b0;
            gmii_txd_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            owner_reg    <= owner_next;
            ifg_cnt_reg  <= ifg_cnt_next;
            start_reg    <= start_next;
            gmii_en_reg  <= gmii_en_next;
            gmii_txd_reg <= gmii_txd_next;
        end
    end

    assign arp_start  = start_reg[0];
    assign icmp_start = start_reg[1];
    assign udp_start  = start_reg[2];
    assign gmii_tx_en = gmii_en_reg;
    assign gmii_txd   = gmii_txd_reg;
    assign owner      = owner_reg;
    assign busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_eth_tx_sched.sv
// Scoreboard bench for eth_tx_sched: stimulus queues expected grants/bytes,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_eth_tx_sched;
    logic       clk = 1'b0;
    logic       rst;
    logic       arp_req, icmp_req, udp_req;
    logic       arp_start, icmp_start, udp_start;
    logic       arp_done, icmp_done, udp_done;
    logic       arp_gmii_tx_en, icmp_gmii_tx_en, udp_gmii_tx_en;
    logic [7:0] arp_gmii_txd, icmp_gmii_txd, udp_gmii_txd;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic [1:0] owner;
    logic       busy, abort;

    eth_tx_sched #(.IFG_CYCLES(12), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .arp_req(arp_req), .icmp_req(icmp_req), .udp_req(udp_req),
        .arp_start(arp_start), .icmp_start(icmp_start), .udp_start(udp_start),
        .arp_done(arp_done), .icmp_done(icmp_done), .udp_done(udp_done),
        .arp_gmii_tx_en(arp_gmii_tx_en), .arp_gmii_txd(arp_gmii_txd),
        .icmp_gmii_tx_en(icmp_gmii_tx_en), .icmp_gmii_txd(icmp_gmii_txd),
        .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd),
        .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
        .owner(owner), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int src;
        int at;
    } start_t;

    start_t     start_q[$];
    logic [7:0] byte_q[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_abort_cyc = -1;

    // Monitor: every grant, every forwarded byte and every abort is checked against the queues.
    always @(negedge clk) begin
        int     src;
        int     nhot;
        start_t e;
        logic [7:0] b;
        if (arp_start || icmp_start || udp_start) begin
            checks++;
            src  = arp_start ? 1 : (icmp_start ? 2 : 3);
            nhot = int'(arp_start) + int'(icmp_start) + int'(udp_start);
            if (start_q.size() == 0) begin
                errors++;
                $display("FAIL start_unexpected cyc=%0d got src=%0d required none", cyc, src);
            end else begin
                e = start_q.pop_front();
                if (e.src != src || e.at != cyc || int'(owner) != src || nhot != 1) begin
                    errors++;
                    $display("FAIL start_grant got src=%0d cyc=%0d owner=%0d hot=%0d required src=%0d cyc=%0d owner=%0d hot=1",
                             src, cyc, owner, nhot, e.src, e.at, e.src);
                end
            end
        end
        if (gmii_tx_en) begin
            checks++;
            if (byte_q.size() == 0) begin
                errors++;
                $display("FAIL gmii_unexpected cyc=%0d got txd=%02h required tx_en=0", cyc, gmii_txd);
            end else begin
                b = byte_q.pop_front();
                if (gmii_txd !== b) begin
                    errors++;
                    $display("FAIL gmii_byte cyc=%0d got %02h required %02h", cyc, gmii_txd, b);
                end
            end
        end
        if (abort || (exp_abort_cyc >= 0 && cyc == exp_abort_cyc)) begin
            checks++;
            if (!(abort === 1'b1 && cyc == exp_abort_cyc)) begin
                errors++;
                $display("FAIL abort_pulse cyc=%0d got abort=%0b required abort at cyc %0d", cyc, abort, exp_abort_cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_req(input logic [2:0] m);
        arp_req  = m[0];
        icmp_req = m[1];
        udp_req  = m[2];
    endtask

    task automatic set_src(input int src, input logic en, input logic [7:0] d, input logic dn);
        case (src)
            1: begin arp_gmii_tx_en = en;  arp_gmii_txd = d;  arp_done = dn;  end
            2: begin icmp_gmii_tx_en = en; icmp_gmii_txd = d; icmp_done = dn; end
            default: begin udp_gmii_tx_en = en; udp_gmii_txd = d; udp_done = dn; end
        endcase
    endtask

    task automatic push_start(input int src, input int at);
        start_t e;
        e.src = src;
        e.at  = at;
        start_q.push_back(e);
    endtask

    task automatic check(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s cyc=%0d got %0d required %0d", name, cyc, got, req);
        end
    endtask

    function automatic logic start_of(input int src);
        case (src)
            1:       return arp_start;
            2:       return icmp_start;
            default: return udp_start;
        endcase
    endfunction

    task automatic wait_start(input int src, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (start_of(src)) seen = 1;
            else tick();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_start src=%0d got no start within %0d cycles required start", src, budget);
        end
    endtask

    // Source model: n bytes, then done with tx_en low; optional req pulses at byte 0 and 2.
    task automatic frame(input int src, input int n, input int next_src,
                         input logic [7:0] base, input logic [2:0] mid_req);
        for (int k = 0; k < n; k++) begin
            set_src(src, 1'b1, base + 8'(k), 1'b0);
            byte_q.push_back(base + 8'(k));
            set_req((k == 0 || k == 2) ? mid_req : 3'b000);
            tick();
        end
        set_req(3'b000);
        set_src(src, 1'b0, 8'h00, 1'b1);
        if (next_src != 0) push_start(next_src, cyc + 14);
        tick();
        set_src(src, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got no finish required finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int s;
        rst = 1'b1;
        set_req(3'b000);
        for (int i = 1; i <= 3; i++) set_src(i, 1'b0, 8'h00, 1'b0);
        tick(); tick();
        check("rst_owner", int'(owner), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_gmii_en", int'(gmii_tx_en), 0);
        check("rst_gmii_txd", int'(gmii_txd), 0);
        check("rst_starts", int'({arp_start, icmp_start, udp_start}), 0);
        check("rst_abort", int'(abort), 0);
        rst = 1'b0;
        tick(); tick();

        // Single UDP frame, then exact IFG length and return to idle.
        set_req(3'b100); push_start(3, cyc + 2); tick(); set_req(3'b000);
        wait_start(3, 10);
        frame(3, 4, 0, 8'h30, 3'b000);
        for (int i = 0; i < 12; i++) begin
            check("ifg_gmii_en", int'(gmii_tx_en), 0);
            check("ifg_busy", int'(busy), 1);
            tick();
        end
        check("post_ifg_busy", int'(busy), 0);
        check("post_ifg_owner", int'(owner), 0);
        repeat (5) tick();

        // Simultaneous requests: priority order, IFG-separated grants.
        set_req(3'b111); push_start(1, cyc + 2); tick(); set_req(3'b000);
        wait_start(1, 10);
        frame(1, 3, 2, 8'h10, 3'b000);
        wait_start(2, 20);
        frame(2, 2, 3, 8'h20, 3'b000);
        wait_start(3, 20);
        frame(3, 2, 0, 8'h40, 3'b000);
        repeat (20) tick();

        // Non-owner ICMP driving the bus, two UDP reqs during ARP: one UDP grant only.
        icmp_gmii_tx_en = 1'b1; icmp_gmii_txd = 8'hEE;
        set_req(3'b001); push_start(1, cyc + 2); tick(); set_req(3'b000);
        wait_start(1, 10);
        frame(1, 4, 3, 8'h50, 3'b100);
        wait_start(3, 20);
        frame(3, 2, 0, 8'h60, 3'b000);
        repeat (30) tick();
        icmp_gmii_tx_en = 1'b0; icmp_gmii_txd = 8'h00;

        // UDP req held across its own grant edge: flag survives, second frame follows.
        set_req(3'b100); push_start(3, cyc + 2); tick(); tick(); set_req(3'b000);
        wait_start(3, 10);
        frame(3, 2, 3, 8'h70, 3'b000);
        wait_start(3, 20);
        frame(3, 2, 0, 8'h78, 3'b000);
        repeat (30) tick();

        // Reset mid-ICMP frame with ARP pending and a UDP req during reset: all lost.
        set_req(3'b010); push_start(2, cyc + 2); tick(); set_req(3'b000);
        wait_start(2, 10);
        for (int k = 0; k < 3; k++) begin
            set_src(2, 1'b1, 8'h90 + 8'(k), 1'b0);
            byte_q.push_back(8'h90 + 8'(k));
            set_req(k == 1 ? 3'b001 : 3'b000);
            tick();
        end
        set_src(2, 1'b0, 8'h00, 1'b0);
        rst = 1'b1; set_req(3'b100);
        tick();
        rst = 1'b0; set_req(3'b000);
        check("rstmid_owner", int'(owner), 0);
        check("rstmid_busy", int'(busy), 0);
        check("rstmid_gmii_en", int'(gmii_tx_en), 0);
        check("rstmid_gmii_txd", int'(gmii_txd), 0);
        repeat (30) tick();
        check("rstmid_no_grant_busy", int'(busy), 0);

`ifdef ETH_TX_TIMEOUT_EN
        // Watchdog: ARP never signals done; abort at ACTIVE cycle 16, then ICMP.
        set_req(3'b011); push_start(1, cyc + 2); tick(); set_req(3'b000);
        wait_start(1, 10);
        s = cyc;
        exp_abort_cyc = s + 15;
        for (int k = 0; k < 16; k++) begin
            set_src(1, 1'b1, 8'hA0 + 8'(k), 1'b0);
            if (k < 15) byte_q.push_back(8'hA0 + 8'(k));
            tick();
        end
        set_src(1, 1'b0, 8'h00, 1'b0);
        check("abort_gmii_drop", int'(gmii_tx_en), 0);
        push_start(2, s + 29);
        wait_start(2, 40);
        frame(2, 2, 0, 8'hC0, 3'b000);
        repeat (20) tick();
        exp_abort_cyc = -1;
`else
        s = cyc;
        check("no_watchdog_abort", int'(abort), 0);
`endif

        check("start_q_drained", start_q.size(), 0);
        check("byte_q_drained", byte_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_sched.md
ETH_TX_SCHED -- requirements
Module: eth_tx_sched

Interface
REQ-001 Parameter IFG_CYCLES, default 12: idle cycles enforced between consecutive frames.
REQ-002 Parameter TIMEOUT_CYCLES, default 4096: maximum ACTIVE cycles before watchdog abort; used only when ETH_TX_TIMEOUT_EN is defined.
REQ-003 clk  in  1  single clock for the whole block (GMII TX clock domain).
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 arp_req / icmp_req / udp_req  in  1 each  single-cycle pulse, source has a frame to send.
REQ-006 arp_start / icmp_start / udp_start  out  1 each  single-cycle grant pulse that launches the source's TX engine.
REQ-007 arp_done / icmp_done / udp_done  in  1 each  single-cycle pulse, source finished its frame.
REQ-008 arp_gmii_tx_en, icmp_gmii_tx_en, udp_gmii_tx_en  in  1 each; arp_gmii_txd, icmp_gmii_txd, udp_gmii_txd  in  8 each  per-source GMII TX data.
REQ-009 gmii_tx_en  out  1; gmii_txd  out  8  muxed GMII TX toward the RGMII converter.
REQ-010 owner  out  2  current grant holder: 0 none, 1 ARP, 2 ICMP, 3 UDP.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 abort  out  1  single-cycle pulse on watchdog abort (tied 0 when macro undefined).

Function
REQ-013 A per-source pending flag is set on the clock edge after its req pulse and cleared on the edge its start pulse is issued; set and clear in the same cycle leave the flag set.
REQ-014 A req arriving while the same source is already pending or active is merged into the single pending flag (one-deep, no counting).
REQ-015 States: IDLE, ACTIVE, IFG.
REQ-016 IDLE -> ACTIVE on the first edge where any pending flag is set; fixed priority ARP > ICMP > UDP selects the winner.
REQ-017 On that transition, owner is loaded and exactly one start output pulses high for one cycle, coincident with the first ACTIVE cycle.
REQ-018 ACTIVE -> IFG on the edge after owner's done pulse is sampled; done from a non-owner is ignored.
REQ-019 IFG lasts exactly IFG_CYCLES cycles (counter loaded with IFG_CYCLES-1, decremented to 0), then -> IDLE with owner = 0.
REQ-020 IFG_CYCLES = 0 is legal: ACTIVE -> IDLE directly on done.
REQ-021 Minimum req-to-start latency is 1 cycle (req at edge N, start high in cycle N+1) from IDLE with no other pending.
REQ-022 gmii_tx_en/gmii_txd are registered: one-cycle delay from the owner's gmii inputs while ACTIVE, including the done cycle; forced to 0/8'h00 in IDLE and IFG.
REQ-023 Non-owner gmii inputs never reach the outputs, even if asserted.
REQ-024 Requests arriving during ACTIVE or IFG are held and arbitrated only on return to IDLE; no preemption.

Reset
REQ-025 While rst is high on a clock edge: state IDLE, all pending flags 0, owner 0, busy 0, all start outputs 0, abort 0, gmii_tx_en 0, gmii_txd 8'h00, IFG and watchdog counters 0.
REQ-026 Reset asserted mid-frame discards the frame and all pending requests; req pulses coincident with rst are lost.

Configuration
REQ-027 Macro ETH_TX_TIMEOUT_EN defined: a watchdog counts ACTIVE cycles; on reaching TIMEOUT_CYCLES without owner done, abort pulses one cycle, gmii_tx_en drops to 0 next cycle, state -> IFG; the aborted source's pending flag is not re-set.
REQ-028 Macro undefined: no watchdog logic; ACTIVE waits indefinitely for done; abort tied to 0.

Verification
REQ-029 udp_req pulse alone from IDLE -> udp_start high next cycle, owner=3, udp_gmii data appears on gmii_txd one cycle later; udp_done -> 12 IFG cycles of gmii_tx_en=0 -> IDLE.
REQ-030 arp_req, icmp_req, udp_req in same cycle -> grants in order ARP, ICMP, UDP, each separated by exactly 12 idle cycles after its done.
REQ-031 udp_req during active ARP frame with icmp_gmii_tx_en driven high -> gmii outputs carry only ARP bytes; UDP granted after ARP done + IFG.
REQ-032 Two udp_req pulses while UDP pending -> exactly one udp_start.
REQ-033 rst high for 1 cycle mid-ICMP frame -> next cycle owner=0, gmii_tx_en=0, pending cleared, no start until new req.
REQ-034 ETH_TX_TIMEOUT_EN defined, TIMEOUT_CYCLES=16, ARP granted, arp_done withheld -> abort pulse at ACTIVE cycle 16, gmii_tx_en 0 next cycle, pending ICMP granted after IFG.
